msrv32_img_pipe: RTL

Registered, parametrised successor to the combinational immediate generator. Accepts a decoded instruction slice, immediate type and PC through a valid/ready handshake. Produces the XLEN-wide sign/zero-extended immediate plus the PC-relative target (pc + imm) one cycle later. Sits between decode and the branch/ALU operand stage, and absorbs downstream stalls without dropping or reordering instructions.

---
 rtl/msrv32_pkg.sv | 13 +
 rtl/msrv32_imm_decode.sv | 34 +++
 rtl/msrv32_img_pipe.sv | 112 +++++++++++
 3 files changed

// File: rtl/msrv32_pkg.sv
// Shared immediate-type encodings for the msrv32 decode/operand path.
package msrv32_pkg;

  localparam logic [2:0] R_TYPE    = 3'b000;
  localparam logic [2:0] I_TYPE    = 3'b001;
  localparam logic [2:0] S_TYPE    = 3'b010;
  localparam logic [2:0] B_TYPE    = 3'b011;
  localparam logic [2:0] U_TYPE    = 3'b100;
  localparam logic [2:0] J_TYPE    = 3'b101;
  localparam logic [2:0] CSR_TYPE  = 3'b110;
  localparam logic [2:0] IMM_SPARE = 3'b111;

endpackage

// File: rtl/msrv32_imm_decode.sv
// Combinational immediate decode of instr[31:7] by immediate type, extended to XLEN.
// No state, no handshake; XLEN is 32 or 64.
module msrv32_imm_decode
  import msrv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [24:0]     instr,
  input  logic [2:0]      imm_type,
  output logic [XLEN-1:0] imm
);

  logic [31:7]        w;
  logic signed [31:0] imm32;

  assign w = instr;

  always_comb begin
    imm32 = {{20{w[31]}}, w[31:20]};
    case (imm_type)
      R_TYPE, I_TYPE, IMM_SPARE: imm32 = {{20{w[31]}}, w[31:20]};
      S_TYPE:   imm32 = {{20{w[31]}}, w[31:25], w[11:7]};
      B_TYPE:   imm32 = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      U_TYPE:   imm32 = {w[31:12], 12'h000};
      J_TYPE:   imm32 = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      CSR_TYPE: imm32 = {27'b0, w[19:15]};
      default:  imm32 = {{20{w[31]}}, w[31:20]};
    endcase
  end

  // CSR immediates have bit 31 clear, so one signed widening serves every type.
  assign imm = XLEN'(imm32);

endmodule

// File: rtl/msrv32_img_pipe.sv
// Registered immediate + pc-relative target generator, 1-cycle latency, valid/ready both sides.
// IMG_SKID_EN adds a skid entry so ready_out is a register; otherwise ready_out = !valid_out || ready_in.
module msrv32_img_pipe
  import msrv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [24:0]      instr_in,
  input  logic [2:0]       imm_type_in,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [XLEN-1:0]  imm_out,
  output logic [XLEN-1:0]  target_out,
  output logic [TAG_W-1:0] tag_out
);

  logic [XLEN-1:0]  dec_imm;
  logic [XLEN-1:0]  dec_target;
  logic             push;
  logic             pop;

  logic             main_vld;
  logic [XLEN-1:0]  main_imm;
  logic [XLEN-1:0]  main_target;
  logic [TAG_W-1:0] main_tag;

  msrv32_imm_decode #(.XLEN(XLEN)) u_decode (
    .instr    (instr_in),
    .imm_type (imm_type_in),
    .imm      (dec_imm)
  );

  assign dec_target = pc_in + dec_imm;

  assign push       = valid_in && ready_out;
  assign pop        = main_vld && ready_in;

  assign valid_out  = main_vld;
  assign imm_out    = main_imm;
  assign target_out = main_target;
  assign tag_out    = main_tag;

`ifdef IMG_SKID_EN
  logic             skid_vld;
  logic [XLEN-1:0]  skid_imm;
  logic [XLEN-1:0]  skid_target;
  logic [TAG_W-1:0] skid_tag;
  logic             rdy_q;

  assign ready_out = rdy_q;

  // rdy_q tracks !skid_vld; a push can never coincide with a full skid.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      main_vld    <= 1'b0;
      main_imm    <= '0;
      main_target <= '0;
      main_tag    <= '0;
      skid_vld    <= 1'b0;
      skid_imm    <= '0;
      skid_target <= '0;
      skid_tag    <= '0;
      rdy_q       <= 1'b1;
    end else if (pop && skid_vld) begin
      main_imm    <= skid_imm;
      main_target <= skid_target;
      main_tag    <= skid_tag;
      skid_vld    <= 1'b0;
      rdy_q       <= 1'b1;
    end else if (push && (!main_vld || pop)) begin
      main_vld    <= 1'b1;
      main_imm    <= dec_imm;
      main_target <= dec_target;
      main_tag    <= tag_in;
    end else if (push) begin
      skid_vld    <= 1'b1;
      skid_imm    <= dec_imm;
      skid_target <= dec_target;
      skid_tag    <= tag_in;
      rdy_q       <= 1'b0;
    end else if (pop) begin
      main_vld    <= 1'b0;
    end
  end
`else
  assign ready_out = !main_vld || ready_in;

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      main_vld    <= 1'b0;
      main_imm    <= '0;
      main_target <= '0;
      main_tag    <= '0;
    end else if (push) begin
      main_vld    <= 1'b1;
      main_imm    <= dec_imm;
      main_target <= dec_target;
      main_tag    <= tag_in;
    end else if (pop) begin
      main_vld    <= 1'b0;
    end
  end
`endif

endmodule
